palette_ram: RTL

PALETTE_RAM -- requirements
Module: palette_ram

---
 rtl/palette_ram.sv | 124 ++++++++++++
 1 files changed

// File: rtl/palette_ram.sv
// Banked colour palette: self-initialising 1W/1R lookup memory with
// double-buffered display bank switched on frame boundaries.
module palette_ram #(
  parameter int                   IDX_W      = 4,
  parameter int                   COLOR_W    = 16,
  parameter int                   BANK_W     = 1,
  parameter logic [COLOR_W-1:0]   INIT_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_valid,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_ready,
  output logic               out_valid,
  output logic [COLOR_W-1:0] out_color,
  input  logic               wr_valid,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COLOR_W-1:0] wr_color,
  output logic               wr_ready,
  input  logic [BANK_W-1:0]  bank_req,
  input  logic               frame_start,
  output logic [BANK_W-1:0]  active_bank,
  output logic               init_busy
);

  localparam int AW = BANK_W + IDX_W;
  localparam int N  = 1 << AW;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_init_cnt;
  logic [COLOR_W-1:0]  r_mem [0:N-1];
  logic                r_out_valid;
  logic [COLOR_W-1:0]  r_out_color;
  logic [BANK_W-1:0]   r_active_bank;

  logic                w_init_busy;
  logic                w_rd_ready;
  logic                w_wr_ready;
  logic                w_mem_we;
  logic [AW-1:0]       w_mem_addr;
  logic [COLOR_W-1:0]  w_mem_wdata;
  logic                w_rd_fire;
  logic [AW-1:0]       w_rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // The single write port is shared: sweep fill in INIT, host writes in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_init_busy = 1'b1;
    w_rd_ready  = 1'b0;
    w_wr_ready  = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_init_cnt;
    w_mem_wdata = INIT_COLOR;
    unique case (r_state)
      S_INIT: begin
        w_mem_we = 1'b1;
        if (r_init_cnt == {AW{1'b1}}) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_init_busy = 1'b0;
        w_rd_ready  = 1'b1;
        w_wr_ready  = 1'b1;
        w_mem_we    = wr_valid;
        w_mem_addr  = {wr_bank, wr_idx};
        w_mem_wdata = wr_color;
      end
    endcase
  end

  assign w_rd_fire = rd_valid & w_rd_ready;
  assign w_rd_addr = {r_active_bank, rd_idx};

  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Non-blocking read of r_mem yields read-first on same-address collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_color   <= '0;
      r_active_bank <= '0;
    end else begin
      r_out_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_out_color <= r_mem[w_rd_addr];
      end
      if (frame_start && r_state == S_RUN) begin
        r_active_bank <= bank_req;
      end
    end
  end

  assign rd_ready    = w_rd_ready;
  assign wr_ready    = w_wr_ready;
  assign init_busy   = w_init_busy;
  assign out_valid   = r_out_valid;
  assign out_color   = r_out_color;
  assign active_bank = r_active_bank;

endmodule
